// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared constants for the byte-serial adder: FSM encodings, default slice count
// and the signed-overflow helper.
package byte_serial_add_ctrl_pkg;

    localparam int unsigned NUM_BYTES_DEF = 4;
    localparam int unsigned SLICE_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow: both operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/byte_serial_add_ctrl_cla.sv
// Eight-bit carry-lookahead slice: sum plus group generate/propagate so the caller
// can form the slice carry-out as G | (P & cin).
module eight_bit_cla
    import byte_serial_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_g,
    output logic               o_p
);

    logic [SLICE_W-1:0] w_gen;
    logic [SLICE_W-1:0] w_prp;
    logic               w_c_acc;
    logic               w_g_acc;

    assign w_gen = i_a & i_b;
    assign w_prp = i_a ^ i_b;

    // Bit carries and group generate built from the per-bit generate/propagate terms.
    always_comb begin
        w_c_acc = i_cin;
        w_g_acc = 1'b0;
        o_sum   = {SLICE_W{1'b0}};
        for (int i = 0; i < SLICE_W; i++) begin
            o_sum[i] = w_prp[i] ^ w_c_acc;
            w_c_acc  = w_gen[i] | (w_prp[i] & w_c_acc);
            w_g_acc  = w_gen[i] | (w_prp[i] & w_g_acc);
        end
        o_g = w_g_acc;
        o_p = &w_prp;
    end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial add/subtract controller: one shared 8-bit CLA processes one byte
// slice per cycle, least significant slice first.
module byte_serial_add_ctrl
    import byte_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BYTES = NUM_BYTES_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_sub,
    input  logic [8*NUM_BYTES-1:0] i_op_a,
    input  logic [8*NUM_BYTES-1:0] i_op_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [8*NUM_BYTES-1:0] o_result,
    output logic                   o_c_out,
    output logic                   o_overflow
);

    localparam int unsigned W     = SLICE_W * NUM_BYTES;
    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_result;
    logic               r_c_out;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic [SLICE_W-1:0] w_a_byte;
    logic [SLICE_W-1:0] w_b_byte;
    logic [SLICE_W-1:0] w_sum;
    logic               w_g;
    logic               w_p;
    logic               w_carry_next;
    logic               w_last;

    assign w_a_byte     = r_a[SLICE_W*r_idx +: SLICE_W];
    assign w_b_byte     = r_b[SLICE_W*r_idx +: SLICE_W];
    assign w_carry_next = w_g | (w_p & r_carry);
    assign w_last       = (r_idx == LAST_IDX);

    eight_bit_cla u_cla (
        .i_a   (w_a_byte),
        .i_b   (w_b_byte),
        .i_cin (r_carry),
        .o_sum (w_sum),
        .o_g   (w_g),
        .o_p   (w_p)
    );

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next   = ST_BUSY;
                    w_accept = 1'b1;
                end else begin
                    w_next   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_BUSY;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_BUSY);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Operand capture and one slice per BUSY cycle; B is pre-inverted for subtract.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx    <= {IDX_W{1'b0}};
            r_carry  <= 1'b0;
            r_a      <= {W{1'b0}};
            r_b      <= {W{1'b0}};
            r_result <= {W{1'b0}};
            r_c_out  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_op_a;
            r_b     <= i_op_b ^ {W{i_sub}};
            r_carry <= i_sub;
            r_idx   <= {IDX_W{1'b0}};
        end else if (r_state == ST_BUSY) begin
            r_result[SLICE_W*r_idx +: SLICE_W] <= w_sum;
            r_carry <= w_carry_next;
            if (w_last) begin
                r_c_out <= w_carry_next;
                r_ovf   <= signed_ovf(r_a[W-1], r_b[W-1], w_sum[SLICE_W-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_result   = r_result;
    assign o_c_out    = r_c_out;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Directed self-checking bench for byte_serial_add_ctrl with NUM_BYTES = 4.
module tb_byte_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic        o_c_out;
    logic        o_overflow;

    int total = 0;
    int bad   = 0;

    byte_serial_add_ctrl #(.NUM_BYTES(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_sub      (sub),
        .i_op_a     (op_a),
        .i_op_b     (op_b),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_c_out    (o_c_out),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; the next edge is the accept edge (n=1).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] er, input logic ec,
                          input logic ev, input bit disturb);
        int dones;
        int first_n;
        int both;
        dones = 0; first_n = 0; both = 0;
        op_a = a; op_b = b; sub = s; start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start = 1'b0;
                chk({tag, ".busy"}, 32'(o_busy), 32'd1);
            end
            if (disturb && n == 2) begin
                start = 1'b1; op_a = 32'hFFFFFFFF; op_b = 32'h0F0F0F0F; sub = ~s;
            end
            if (disturb && n == 3) start = 1'b0;
            if (o_busy && o_done) both++;
            if (o_done) begin
                dones++;
                if (first_n == 0) first_n = n;
            end
        end
        chk({tag, ".lat"},   32'(first_n), 32'd5);
        chk({tag, ".ndone"}, 32'(dones),   32'd1);
        chk({tag, ".both"},  32'(both),    32'd0);
        chk({tag, ".res"},   o_result,     er);
        chk({tag, ".cout"},  32'(o_c_out), 32'(ec));
        chk({tag, ".ovf"},   32'(o_overflow), 32'(ev));
    endtask

    initial begin
        int dones;
        int first_n;
        int second_n;
        rst = 1'b0; start = 1'b0; sub = 1'b0; op_a = 32'd0; op_b = 32'd0;
        #2 rst = 1'b1;
        #1;
        chk("rst.busy", 32'(o_busy),     32'd0);
        chk("rst.done", 32'(o_done),     32'd0);
        chk("rst.res",  o_result,        32'd0);
        chk("rst.cout", 32'(o_c_out),    32'd0);
        chk("rst.ovf",  32'(o_overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op("ff_p1",   32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
        run_op("wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run_op("posovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("sub5_7",  32'd5,        32'd7,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub7_5",  32'd7,        32'd5,        1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0);
        run_op("negovf",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        run_op("disturb", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b1);

        // start held high: two accepts, one per IDLE visit
        op_a = 32'd1; op_b = 32'd2; sub = 1'b0; start = 1'b1;
        dones = 0; first_n = 0; second_n = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (o_done) begin
                dones++;
                if (first_n == 0) first_n = n;
                else second_n = n;
            end
            if (n == 11) start = 1'b0;
        end
        chk("b2b.ndone",  32'(dones),    32'd2);
        chk("b2b.first",  32'(first_n),  32'd5);
        chk("b2b.second", 32'(second_n), 32'd11);
        chk("b2b.res",    o_result,      32'd3);

        // reset during the second slice cycle aborts the operation
        op_a = 32'h01010101; op_b = 32'h01010101; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("abort.busy", 32'(o_busy),     32'd0);
        chk("abort.done", 32'(o_done),     32'd0);
        chk("abort.res",  o_result,        32'd0);
        chk("abort.cout", 32'(o_c_out),    32'd0);
        chk("abort.ovf",  32'(o_overflow), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        dones = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) dones++;
        end
        chk("abort.quiet", 32'(dones), 32'd0);
        run_op("post_rst", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
